pattern_seq_editor: RTL and testbench

- Parametrised, multi-pattern successor to the 8-step, 4-sample sequence editor.
- Holds NUM_PATTERNS patterns of NUM_STEPS steps by NUM_TRACKS trigger bits each, in flops.
- Edit operations: strobed toggle, pattern clear, pattern copy. Clear and copy are multi-cycle, FSM-driven.
- Includes a tick-driven playback step counter that emits per-track trigger pulses to the sample players.

---
 rtl/pattern_seq_pkg.sv | 19 +
 rtl/seq_step_counter.sv | 24 ++
 rtl/pattern_seq_editor.sv | 137 +++++++++++++
 tb/tb_pattern_seq_editor.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_seq_pkg.sv
// Shared definitions for the multi-pattern step sequencer: mode encodings,
// clear/copy FSM states and the address-width helper.
package pattern_seq_pkg;

    localparam logic [1:0] MODE_EDIT = 2'b00;
    localparam logic [1:0] MODE_PLAY = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        COPY  = 2'b10
    } seq_state_e;

    // Address width for n entries, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/seq_step_counter.sv
// Modulo-N step counter with enable and synchronous clear; wraps N-1 -> 0
// explicitly so non-power-of-2 step counts work.
module seq_step_counter #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == W'(N - 1)) ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/pattern_seq_editor.sv
// Multi-pattern trigger sequencer: strobed toggle editing, multi-cycle
// clear/copy of whole patterns, and tick-driven playback of one pattern.
module pattern_seq_editor
    import pattern_seq_pkg::*;
#(
    parameter  int unsigned NUM_TRACKS   = 4,
    parameter  int unsigned NUM_STEPS    = 8,
    parameter  int unsigned NUM_PATTERNS = 4,
    localparam int unsigned PW           = idx_width(NUM_PATTERNS),
    localparam int unsigned SW           = idx_width(NUM_STEPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [PW-1:0]         edit_pat,
    input  logic [SW-1:0]         edit_step,
    input  logic                  tgl_valid,
    input  logic [NUM_TRACKS-1:0] tgl_tracks,
    input  logic                  clr_req,
    input  logic                  cpy_req,
    input  logic [PW-1:0]         cpy_src,
    input  logic [PW-1:0]         play_pat,
    input  logic                  step_tick,
    output logic [NUM_TRACKS-1:0] trig,
    output logic [SW-1:0]         play_step,
    output logic [NUM_TRACKS-1:0] edit_row,
    output logic                  busy
);

    // Storage is padded to full address range so every index is legal;
    // padded entries are never written and always read back as zero.
    localparam int unsigned PD = 32'(1) << PW;
    localparam int unsigned SD = 32'(1) << SW;

    logic [NUM_TRACKS-1:0] mem [PD][SD];

    seq_state_e    state;
    logic [SW-1:0] idx;
    logic [PW-1:0] src;
    logic [PW-1:0] dst;

    logic edit_mode;
    logic play_mode;
    logic req_any;
    logic edit_ok;
    logic dst_ok;
    logic tgl_fire;

    assign edit_mode = (mode == MODE_EDIT);
    assign play_mode = (mode == MODE_PLAY);
    assign req_any   = clr_req | cpy_req;
    assign edit_ok   = (32'(edit_pat) < NUM_PATTERNS) && (32'(edit_step) < NUM_STEPS);
    assign dst_ok    = (32'(dst) < NUM_PATTERNS);
    assign tgl_fire  = (state == IDLE) && edit_mode && tgl_valid && !req_any && edit_ok;

    assign edit_row  = mem[edit_pat][edit_step];

    // Clear/copy sequencer: one step written per cycle, NUM_STEPS cycles total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            src   <= '0;
            dst   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (edit_mode && clr_req) begin
                        state <= CLEAR;
                        dst   <= edit_pat;
                        busy  <= 1'b1;
                    end else if (edit_mode && cpy_req) begin
                        state <= COPY;
                        src   <= cpy_src;
                        dst   <= edit_pat;
                        busy  <= 1'b1;
                    end
                end
                CLEAR, COPY: begin
                    if (idx == SW'(NUM_STEPS - 1)) begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + SW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pattern storage; sequencer writes take precedence over toggles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned p = 0; p < PD; p++) begin
                for (int unsigned s = 0; s < SD; s++) begin
                    mem[p][s] <= '0;
                end
            end
        end else if ((state == CLEAR) && dst_ok) begin
            mem[dst][idx] <= '0;
        end else if ((state == COPY) && dst_ok) begin
            mem[dst][idx] <= mem[src][idx];
        end else if (tgl_fire) begin
            mem[edit_pat][edit_step] <= mem[edit_pat][edit_step] ^ tgl_tracks;
        end
    end

    seq_step_counter #(
        .N (NUM_STEPS),
        .W (SW)
    ) u_play_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (play_mode && step_tick),
        .clr   (!play_mode),
        .count (play_step)
    );

    // One-cycle trigger pulse carrying the row at the step being left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig <= '0;
        end else if (play_mode && step_tick) begin
            trig <= mem[play_pat][play_step];
        end else begin
            trig <= '0;
        end
    end

endmodule

// File: tb/tb_pattern_seq_editor.sv
// Bench for pattern_seq_editor: default-parameter instance plus a 6-step,
// 1-pattern, 8-track instance, both checked against an array-based model.
module tb_pattern_seq_editor;

    localparam int NS = 8;
    localparam int NP = 4;
    localparam int NSB = 6;

    localparam int PIN_ROW    = 0;
    localparam int PIN_TRIG   = 1;
    localparam int PIN_STEP   = 2;
    localparam int PIN_BUSY   = 3;
    localparam int PIN_B_ROW  = 4;
    localparam int PIN_B_STEP = 5;
    localparam int PIN_B_TRIG = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] mode;
    logic [1:0] edit_pat;
    logic [2:0] edit_step;
    logic       tgl_valid;
    logic [3:0] tgl_tracks;
    logic       clr_req;
    logic       cpy_req;
    logic [1:0] cpy_src;
    logic [1:0] play_pat;
    logic       step_tick;
    logic [3:0] trig;
    logic [2:0] play_step;
    logic [3:0] edit_row;
    logic       busy;

    logic [1:0] mode_b;
    logic       zero_b;
    logic [2:0] step_b;
    logic       tgl_b;
    logic [7:0] tracks_b;
    logic       tick_b;
    logic [7:0] trig_b;
    logic [2:0] play_step_b;
    logic [7:0] edit_row_b;
    logic       busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic        pin_en = 1'b0;
    int          pin_sel = 0;
    logic [31:0] pin_want = '0;
    string       pin_name = "";

    always #5 clk = ~clk;

    pattern_seq_editor dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .edit_pat   (edit_pat),
        .edit_step  (edit_step),
        .tgl_valid  (tgl_valid),
        .tgl_tracks (tgl_tracks),
        .clr_req    (clr_req),
        .cpy_req    (cpy_req),
        .cpy_src    (cpy_src),
        .play_pat   (play_pat),
        .step_tick  (step_tick),
        .trig       (trig),
        .play_step  (play_step),
        .edit_row   (edit_row),
        .busy       (busy)
    );

    pattern_seq_editor #(
        .NUM_TRACKS   (8),
        .NUM_STEPS    (6),
        .NUM_PATTERNS (1)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode_b),
        .edit_pat   (zero_b),
        .edit_step  (step_b),
        .tgl_valid  (tgl_b),
        .tgl_tracks (tracks_b),
        .clr_req    (zero_b),
        .cpy_req    (zero_b),
        .cpy_src    (zero_b),
        .play_pat   (zero_b),
        .step_tick  (tick_b),
        .trig       (trig_b),
        .play_step  (play_step_b),
        .edit_row   (edit_row_b),
        .busy       (busy_b)
    );

    // Behavioural model: pattern arrays plus a count of outstanding op steps.
    logic [3:0] m [NP][NS];
    int         op_left;
    bit         op_clr;
    int         op_src;
    int         op_dst;
    int         pstep;
    logic [3:0] trig_m;
    logic [7:0] mb [NSB];
    int         pstep_b;
    logic [7:0] trig_mb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m[p, s]) m[p][s] = '0;
            foreach (mb[s]) mb[s] = '0;
            op_left = 0; op_clr = 0; op_src = 0; op_dst = 0;
            pstep = 0; trig_m = '0; pstep_b = 0; trig_mb = '0;
        end else begin
            trig_m = (mode == 2'b01 && step_tick) ? m[play_pat][pstep] : 4'h0;
            if (mode != 2'b01) pstep = 0;
            else if (step_tick) pstep = (pstep + 1) % NS;
            if (op_left > 0) begin
                m[op_dst][NS - op_left] = op_clr ? 4'h0 : m[op_src][NS - op_left];
                op_left--;
            end else if (mode == 2'b00 && (clr_req || cpy_req)) begin
                op_clr  = clr_req;
                op_src  = int'(cpy_src);
                op_dst  = int'(edit_pat);
                op_left = NS;
            end else if (mode == 2'b00 && tgl_valid) begin
                m[edit_pat][edit_step] = m[edit_pat][edit_step] ^ tgl_tracks;
            end

            trig_mb = (mode_b == 2'b01 && tick_b) ? mb[pstep_b] : 8'h00;
            if (mode_b != 2'b01) pstep_b = 0;
            else if (tick_b) pstep_b = (pstep_b + 1) % NSB;
            if (mode_b == 2'b00 && tgl_b) mb[step_b] = mb[step_b] ^ tracks_b;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Single compare process: model every cycle, plus hand-computed pins.
    always @(negedge clk) begin : cmp
        logic [31:0] got;
        chk("trig",        32'(trig),        32'(trig_m));
        chk("play_step",   32'(play_step),   32'(pstep));
        chk("busy",        32'(busy),        32'(op_left > 0));
        chk("edit_row",    32'(edit_row),    32'(m[edit_pat][edit_step]));
        chk("b_trig",      32'(trig_b),      32'(trig_mb));
        chk("b_play_step", 32'(play_step_b), 32'(pstep_b));
        chk("b_busy",      32'(busy_b),      32'(0));
        chk("b_edit_row",  32'(edit_row_b),  32'(mb[step_b]));
        if (pin_en) begin
            case (pin_sel)
                PIN_ROW:    got = 32'(edit_row);
                PIN_TRIG:   got = 32'(trig);
                PIN_STEP:   got = 32'(play_step);
                PIN_BUSY:   got = 32'(busy);
                PIN_B_ROW:  got = 32'(edit_row_b);
                PIN_B_STEP: got = 32'(play_step_b);
                PIN_B_TRIG: got = 32'(trig_b);
                default:    got = '1;
            endcase
            chk(pin_name, got, pin_want);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pin(input int sel, input logic [31:0] want, input string nm);
        pin_sel  = sel;
        pin_want = want;
        pin_name = nm;
        pin_en   = 1'b1;
        @(negedge clk);
        #1 pin_en = 1'b0;
    endtask

    task automatic do_toggle(input int p, input int s, input logic [3:0] msk);
        mode       = 2'b00;
        edit_pat   = 2'(p);
        edit_step  = 3'(s);
        tgl_tracks = msk;
        tgl_valid  = 1'b1;
        step();
        tgl_valid  = 1'b0;
    endtask

    task automatic show_row(input int p, input int s, input logic [3:0] want, input string nm);
        edit_pat  = 2'(p);
        edit_step = 3'(s);
        pin(PIN_ROW, 32'(want), nm);
    endtask

    initial begin
        mode = 2'b10; edit_pat = '0; edit_step = '0; tgl_valid = 0; tgl_tracks = '0;
        clr_req = 0; cpy_req = 0; cpy_src = '0; play_pat = '0; step_tick = 0;
        mode_b = 2'b10; zero_b = 0; step_b = '0; tgl_b = 0; tracks_b = '0; tick_b = 0;
        #1 rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        pin(PIN_ROW,  0, "reset_row");
        pin(PIN_BUSY, 0, "reset_busy");
        pin(PIN_STEP, 0, "reset_play_step");

        // Toggle and untoggle one cell.
        do_toggle(1, 3, 4'b1010);
        pin(PIN_ROW, 32'hA, "toggle_set");
        do_toggle(1, 3, 4'b1010);
        pin(PIN_ROW, 32'h0, "toggle_undo");
        show_row(0, 3, 4'h0, "other_pattern_zero");

        // Playback across the wrap.
        do_toggle(0, 7, 4'b0001);
        do_toggle(0, 0, 4'b1000);
        mode = 2'b01; play_pat = 2'd0; step_tick = 1'b1;
        step();
        pin(PIN_TRIG, 32'h8, "trig_first_tick");
        repeat (6) step();
        step();
        step_tick = 1'b0;
        pin(PIN_TRIG, 32'h1, "trig_eighth_tick");
        pin(PIN_STEP, 0, "play_wrap");

        // Copy pattern 2 into pattern 0 with toggles attempted while busy.
        do_toggle(2, 1, 4'h5);
        do_toggle(2, 4, 4'hC);
        do_toggle(2, 7, 4'h3);
        edit_pat = 2'd0; cpy_src = 2'd2; cpy_req = 1'b1;
        step();
        cpy_req = 1'b0;
        edit_pat = 2'd3; edit_step = 3'd0; tgl_tracks = 4'hF; tgl_valid = 1'b1;
        pin(PIN_BUSY, 1, "copy_busy_first");
        repeat (7) step();
        tgl_valid = 1'b0;
        pin(PIN_BUSY, 1, "copy_busy_last");
        step();
        pin(PIN_BUSY, 0, "copy_done");
        show_row(3, 0, 4'h0, "busy_toggle_dropped");
        show_row(0, 1, 4'h5, "copy_step1");
        show_row(0, 4, 4'hC, "copy_step4");
        show_row(0, 7, 4'h3, "copy_step7");
        show_row(0, 0, 4'h0, "copy_step0");

        // Clear wins over copy and over a same-cycle toggle.
        edit_pat = 2'd0; edit_step = 3'd4; cpy_src = 2'd2; tgl_tracks = 4'hF;
        clr_req = 1'b1; cpy_req = 1'b1; tgl_valid = 1'b1;
        step();
        clr_req = 1'b0; cpy_req = 1'b0; tgl_valid = 1'b0;
        pin(PIN_BUSY, 1, "clear_busy_first");
        repeat (7) step();
        pin(PIN_BUSY, 1, "clear_busy_last");
        step();
        pin(PIN_BUSY, 0, "clear_done");
        show_row(0, 4, 4'h0, "clear_step4");
        show_row(0, 7, 4'h0, "clear_step7");
        show_row(2, 4, 4'hC, "clear_src_untouched");
        mode = 2'b10;

        // Six-step, eight-track instance.
        mode_b = 2'b00; step_b = 3'd5; tracks_b = 8'hA5; tgl_b = 1'b1;
        step();
        tgl_b = 1'b0;
        pin(PIN_B_ROW, 32'hA5, "b_toggle_8bit");
        step_b = 3'd0; tracks_b = 8'h3C; tgl_b = 1'b1;
        step();
        tgl_b = 1'b0;
        mode_b = 2'b01; tick_b = 1'b1;
        step();
        pin(PIN_B_TRIG, 32'h3C, "b_trig_first");
        repeat (4) step();
        pin(PIN_B_STEP, 5, "b_step_last");
        step();
        tick_b = 1'b0;
        pin(PIN_B_TRIG, 32'hA5, "b_trig_sixth");
        pin(PIN_B_STEP, 0, "b_wrap");
        mode_b = 2'b10;

        // Asynchronous reset during the fourth busy cycle of a copy.
        mode = 2'b00; edit_pat = 2'd1; cpy_src = 2'd2; cpy_req = 1'b1;
        step();
        cpy_req = 1'b0;
        mode = 2'b01; step_tick = 1'b1;
        repeat (3) step();
        rst = 1'b1; step_tick = 1'b0;
        pin(PIN_BUSY, 0, "rst_busy");
        pin(PIN_STEP, 0, "rst_play_step");
        edit_pat = 2'd2; edit_step = 3'd4;
        pin(PIN_ROW, 0, "rst_row");
        step();
        rst = 1'b0; mode = 2'b10;

        // Randomised traffic on both instances.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            mode       = (r < 6) ? 2'b00 : (r < 9) ? 2'b01 : 2'($urandom_range(2, 3));
            tgl_valid  = 1'($urandom_range(0, 1));
            edit_pat   = 2'($urandom);
            edit_step  = 3'($urandom);
            tgl_tracks = 4'($urandom);
            clr_req    = ($urandom_range(0, 15) == 0);
            cpy_req    = ($urandom_range(0, 11) == 0);
            cpy_src    = 2'($urandom);
            play_pat   = 2'($urandom);
            step_tick  = ($urandom_range(0, 2) == 0);
            mode_b     = 2'($urandom_range(0, 2));
            tgl_b      = 1'($urandom_range(0, 1));
            step_b     = 3'($urandom_range(0, NSB - 1));
            tracks_b   = 8'($urandom);
            tick_b     = 1'($urandom_range(0, 1));
            step();
        end

        tgl_valid = 0; clr_req = 0; cpy_req = 0; step_tick = 0; tgl_b = 0; tick_b = 0;
        repeat (20) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
